// File: rtl/button_event_arbiter.sv
// Turns N debounced button levels into press/release/long/repeat events and
// funnels them through per-button pending slots into one valid/ready stream.
module button_event_arbiter #(
    parameter int N             = 4,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int IDW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [N-1:0]   BTN,
    output logic           EVT_VALID,
    input  logic           EVT_READY,
    output logic [IDW-1:0] EVT_ID,
    output logic [1:0]     EVT_CODE,
    output logic [N-1:0]   OVERRUN,
    input  logic           CLR_OVR
);

    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0]  REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1'b1);
    localparam logic [IDW-1:0] PTR_RST   = IDW'(N - 1);

    localparam logic [1:0] CODE_PRESS   = 2'b00;
    localparam logic [1:0] CODE_RELEASE = 2'b01;
    localparam logic [1:0] CODE_LONG    = 2'b10;
    localparam logic [1:0] CODE_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD   = 2'b01,
        ST_REPEAT = 2'b10
    } state_t;

    state_t                 state_r   [N];
    state_t                 state_n_s [N];
    logic [N-1:0][CW-1:0]   cnt_r;
    logic [N-1:0][CW-1:0]   cnt_n_s;
    logic [N-1:0]           prev_r;
    logic [N-1:0]           rise_s;
    logic [N-1:0]           fall_s;
    logic [N-1:0]           emit_s;
    logic [N-1:0][1:0]      emit_code_s;

    logic [N-1:0]           pend_r;
    logic [N-1:0]           pend_n_s;
    logic [N-1:0][1:0]      code_r;
    logic [N-1:0][1:0]      code_n_s;
    logic [N-1:0]           gnt_s;
    logic [N-1:0]           ovr_set_s;
    logic [N-1:0]           overrun_r;
    logic [N-1:0]           overrun_n_s;

    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         gnt_idx_s;
    logic [1:0]             gnt_code_s;
    logic                   any_pend_s;
    logic                   load_s;

    logic                   evt_valid_r;
    logic [IDW-1:0]         evt_id_r;
    logic [1:0]             evt_code_r;

    assign EVT_VALID = evt_valid_r;
    assign EVT_ID    = evt_id_r;
    assign EVT_CODE  = evt_code_r;
    assign OVERRUN   = overrun_r;

    // Per-button edge detection and hold-time FSM next state.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rise_s[i]      = BTN[i] & ~prev_r[i];
            fall_s[i]      = ~BTN[i] & prev_r[i];
            state_n_s[i]   = state_r[i];
            cnt_n_s[i]     = cnt_r[i];
            emit_s[i]      = 1'b0;
            emit_code_s[i] = CODE_PRESS;
            case (state_r[i])
                ST_IDLE: begin
                    if (rise_s[i]) begin
                        state_n_s[i]   = ST_HELD;
                        cnt_n_s[i]     = CNT_ZERO;
                        emit_s[i]      = 1'b1;
                        emit_code_s[i] = CODE_PRESS;
                    end else begin
                        state_n_s[i]   = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (fall_s[i]) begin
                        state_n_s[i]   = ST_IDLE;
                        emit_s[i]      = 1'b1;
                        emit_code_s[i] = CODE_RELEASE;
                    end else if (cnt_r[i] == LONG_LAST) begin
                        state_n_s[i]   = ST_REPEAT;
                        cnt_n_s[i]     = CNT_ZERO;
                        emit_s[i]      = 1'b1;
                        emit_code_s[i] = CODE_LONG;
                    end else begin
                        cnt_n_s[i]     = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    // A release in the terminal-count cycle wins; no repeat is emitted.
                    if (fall_s[i]) begin
                        state_n_s[i]   = ST_IDLE;
                        emit_s[i]      = 1'b1;
                        emit_code_s[i] = CODE_RELEASE;
                    end else if (cnt_r[i] == REP_LAST) begin
                        cnt_n_s[i]     = CNT_ZERO;
                        emit_s[i]      = 1'b1;
                        emit_code_s[i] = CODE_REPEAT;
                    end else begin
                        cnt_n_s[i]     = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_n_s[i] = ST_IDLE;
                    cnt_n_s[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Round-robin grant: lowest pending index above ptr, else lowest at or below it.
    always_comb begin
        load_s     = ~evt_valid_r | EVT_READY;
        any_pend_s = |pend_r;
        gnt_idx_s  = ptr_r;
        gnt_code_s = CODE_PRESS;
        gnt_s      = {N{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            gnt_idx_s  = (pend_r[i] && (IDW'(i) <= ptr_r)) ? IDW'(i)   : gnt_idx_s;
            gnt_code_s = (pend_r[i] && (IDW'(i) <= ptr_r)) ? code_r[i] : gnt_code_s;
        end
        for (int i = N - 1; i >= 0; i--) begin
            gnt_idx_s  = (pend_r[i] && (IDW'(i) > ptr_r)) ? IDW'(i)   : gnt_idx_s;
            gnt_code_s = (pend_r[i] && (IDW'(i) > ptr_r)) ? code_r[i] : gnt_code_s;
        end
        for (int i = 0; i < N; i++) begin
            gnt_s[i] = load_s & any_pend_s & (gnt_idx_s == IDW'(i));
        end
    end

    // Pending slot update and sticky overrun detection.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ovr_set_s[i] = emit_s[i] & pend_r[i] & ~gnt_s[i];
            if (emit_s[i]) begin
                pend_n_s[i] = 1'b1;
                code_n_s[i] = emit_code_s[i];
            end else if (gnt_s[i]) begin
                pend_n_s[i] = 1'b0;
                code_n_s[i] = code_r[i];
            end else begin
                pend_n_s[i] = pend_r[i];
                code_n_s[i] = code_r[i];
            end
        end
        overrun_n_s = (CLR_OVR ? {N{1'b0}} : overrun_r) | ovr_set_s;
    end

    // Per-button state, pending slots and overrun flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= ST_IDLE;
            end
            cnt_r     <= {N{CNT_ZERO}};
            prev_r    <= {N{1'b0}};
            pend_r    <= {N{1'b0}};
            code_r    <= {N{CODE_PRESS}};
            overrun_r <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= state_n_s[i];
            end
            cnt_r     <= cnt_n_s;
            prev_r    <= BTN;
            pend_r    <= pend_n_s;
            code_r    <= code_n_s;
            overrun_r <= overrun_n_s;
        end
    end

    // Output register and round-robin pointer; holds contents while stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_valid_r <= 1'b0;
            evt_id_r    <= {IDW{1'b0}};
            evt_code_r  <= CODE_PRESS;
            ptr_r       <= PTR_RST;
        end else if (load_s) begin
            if (any_pend_s) begin
                evt_valid_r <= 1'b1;
                evt_id_r    <= gnt_idx_s;
                evt_code_r  <= gnt_code_s;
                ptr_r       <= gnt_idx_s;
            end else begin
                evt_valid_r <= 1'b0;
            end
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed table-driven bench for button_event_arbiter (N=4, LONG=8, REPEAT=4).
module tb_button_event_arbiter;

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] eid;
        logic [1:0] ecode;
        logic [3:0] eovr;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] BTN;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [1:0] EVT_ID;
    logic [1:0] EVT_CODE;
    logic [3:0] OVERRUN;
    logic       CLR_OVR;

    int   total = 0;
    int   bad   = 0;
    vec_t vq[$];

    always #5 CLK = ~CLK;

    button_event_arbiter #(
        .N(4),
        .LONG_CYCLES(8),
        .REPEAT_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN(BTN),
        .EVT_VALID(EVT_VALID),
        .EVT_READY(EVT_READY),
        .EVT_ID(EVT_ID),
        .EVT_CODE(EVT_CODE),
        .OVERRUN(OVERRUN),
        .CLR_OVR(CLR_OVR)
    );

    function automatic void add(input logic [3:0] b, input logic r, input logic c,
                                input logic v, input logic [1:0] id, input logic [1:0] cd,
                                input logic [3:0] o);
        vec_t x;
        x.btn = b; x.rdy = r; x.clr = c; x.ev = v; x.eid = id; x.ecode = cd; x.eovr = o;
        vq.push_back(x);
    endfunction

    // strict also compares ID/CODE when no event is expected (reset values).
    task automatic check(input string nm, input logic v, input logic [1:0] id,
                         input logic [1:0] cd, input logic [3:0] o, input logic strict);
        total++;
        if (EVT_VALID !== v || OVERRUN !== o ||
            ((v || strict) && (EVT_ID !== id || EVT_CODE !== cd))) begin
            bad++;
            $display("FAIL %s: got valid=%b id=%0d code=%b ovr=%b, want valid=%b id=%0d code=%b ovr=%b",
                     nm, EVT_VALID, EVT_ID, EVT_CODE, OVERRUN, v, id, cd, o);
        end
    endtask

    initial begin
        RST_N = 1'b0; BTN = 4'b0000; EVT_READY = 1'b1; CLR_OVR = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check("reset", 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1);
        @(negedge CLK) RST_N = 1'b1;

        // Simultaneous presses/releases: ptr=3 after reset, then ptr=1.
        add(4'b1111,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd0,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd1,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd2,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd3,2'b00,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 1,2'd0,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd1,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd2,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd3,2'b01,4'b0000);
        add(4'b0010,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 1,2'd1,2'b00,4'b0000);   // grant and refill in one cycle, no overrun
        add(4'b0000,1,0, 1,2'd1,2'b01,4'b0000);
        add(4'b1111,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd2,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd3,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd0,2'b00,4'b0000);
        add(4'b1111,1,0, 1,2'd1,2'b00,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 1,2'd2,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd3,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd0,2'b01,4'b0000);
        add(4'b0000,1,0, 1,2'd1,2'b01,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);

        // Short press on button 2: press then release, no long.
        add(4'b0100,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0100,1,0, 1,2'd2,2'b00,4'b0000);
        add(4'b0100,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 1,2'd2,2'b01,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);

        // Button 1 held 20 edges: press, long, two repeats, release on terminal count.
        for (int t = 0; t < 23; t++) begin
            logic [3:0] b;
            b = (t < 20) ? 4'b0010 : 4'b0000;
            if (t == 1)                  add(b,1,0, 1,2'd1,2'b00,4'b0000);
            else if (t == 9)             add(b,1,0, 1,2'd1,2'b10,4'b0000);
            else if (t == 13 || t == 17) add(b,1,0, 1,2'd1,2'b11,4'b0000);
            else if (t == 21)            add(b,1,0, 1,2'd1,2'b01,4'b0000);
            else                         add(b,1,0, 0,2'd0,2'b00,4'b0000);
        end

        // Stall: output holds button 3 press while button 0 press is overwritten.
        add(4'b1000,0,0, 0,2'd0,2'b00,4'b0000);
        add(4'b1001,0,0, 1,2'd3,2'b00,4'b0000);
        add(4'b1001,0,0, 1,2'd3,2'b00,4'b0000);
        add(4'b1000,0,0, 1,2'd3,2'b00,4'b0001);
        add(4'b1000,0,0, 1,2'd3,2'b00,4'b0001);
        add(4'b1000,0,0, 1,2'd3,2'b00,4'b0001);
        add(4'b1000,1,1, 1,2'd0,2'b01,4'b0000);
        add(4'b1000,1,0, 0,2'd0,2'b00,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);   // fall coincides with long terminal count
        add(4'b0000,1,0, 1,2'd3,2'b01,4'b0000);
        add(4'b0000,1,0, 0,2'd0,2'b00,4'b0000);

        foreach (vq[k]) begin
            @(negedge CLK);
            BTN = vq[k].btn; EVT_READY = vq[k].rdy; CLR_OVR = vq[k].clr;
            @(posedge CLK);
            #1 check($sformatf("vec%0d", k), vq[k].ev, vq[k].eid, vq[k].ecode, vq[k].eovr, 1'b0);
        end

        // Reset mid-hold with a stalled valid event, button kept pressed.
        for (int t = 0; t < 11; t++) begin
            @(negedge CLK);
            BTN = 4'b0010; EVT_READY = 1'b0; CLR_OVR = 1'b0;
            @(posedge CLK);
            if (t == 0) #1 check("hold_t0", 1'b0, 2'd0, 2'b00, 4'b0000, 1'b0);
            else        #1 check($sformatf("hold_t%0d", t), 1'b1, 2'd1, 2'b00, 4'b0000, 1'b0);
        end
        #2 RST_N = 1'b0;
        #1 check("async_reset", 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1);
        @(posedge CLK);
        @(negedge CLK) begin RST_N = 1'b1; EVT_READY = 1'b1; end
        @(posedge CLK);
        #1 check("post_reset_edge1", 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1);
        @(posedge CLK);
        #1 check("post_reset_press", 1'b1, 2'd1, 2'b00, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
